// File: rtl/fpu_dp_pkg.sv
// Shared opcodes, scheduler FSM encoding and IEEE-754 double constants
// used by the fpu_dp scheduler and the FPU benches.
package fpu_dp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam logic [63:0] DP_POS_INF  = 64'h7FF0000000000000;
  localparam logic [63:0] DP_POS_ZERO = 64'h0000000000000000;

endpackage

// File: rtl/fpu_dp_rr_arbiter.sv
// Combinational round-robin grant: the first requester after ptr (with wrap)
// wins; enable=0 forces an all-zero grant. Pointer state lives in the caller.
module fpu_dp_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_dp_scheduler.sv
// Round-robin sharing of one fpu_dp across NUM_REQ requesters; one op in flight, response
// FPU_LATENCY+1 cycles after accept, held until rsp_ready. FPU_DP_SCHED_STICKY_FLAGS_EN adds sticky flags.
module fpu_dp_scheduler #(
  parameter int  WIDTH       = 64,
  parameter int  NUM_REQ     = 2,
  parameter int  FPU_LATENCY = 2,
  localparam int ID_W        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [2*NUM_REQ-1:0]     req_op,
  output logic [WIDTH-1:0]         fpu_a,
  output logic [WIDTH-1:0]         fpu_b,
  output logic [1:0]               fpu_opcode,
  input  logic [WIDTH-1:0]         fpu_result,
  input  logic                     fpu_overflow,
  input  logic                     fpu_underflow,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_overflow,
  output logic                     rsp_underflow,
  output logic [ID_W-1:0]          rsp_id
`ifdef FPU_DP_SCHED_STICKY_FLAGS_EN
  ,
  input  logic                     sts_clear,
  output logic                     sts_overflow,
  output logic                     sts_underflow
`endif
);

  import fpu_dp_pkg::*;

  localparam int CNT_W = $clog2(FPU_LATENCY + 1);

  sched_state_t       state_q, state_d;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    win_idx;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic               capture;

  logic [WIDTH-1:0]   a_sel  [NUM_REQ];
  logic [WIDTH-1:0]   b_sel  [NUM_REQ];
  logic [1:0]         op_sel [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_sel[g]  = req_a[g*WIDTH +: WIDTH];
    assign b_sel[g]  = req_b[g*WIDTH +: WIDTH];
    assign op_sel[g] = req_op[2*g +: 2];
  end

  fpu_dp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .enable (state_q == IDLE),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  // The FPU result is valid once the countdown has consumed FPU_LATENCY edges.
  assign capture   = (state_q == WAIT) && (cnt_q == '0);

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = WAIT;
      WAIT:    if (capture)   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= ID_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      fpu_a         <= '0;
      fpu_b         <= '0;
      fpu_opcode    <= '0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_overflow  <= 1'b0;
      rsp_underflow <= 1'b0;
      rsp_id        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        fpu_a      <= a_sel[win_idx];
        fpu_b      <= b_sel[win_idx];
        fpu_opcode <= op_sel[win_idx];
        ptr_q      <= win_idx;
        rsp_id     <= win_idx;
        cnt_q      <= CNT_W'(FPU_LATENCY);
      end
      if (state_q == WAIT && !capture) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (capture) begin
        rsp_result    <= fpu_result;
        rsp_overflow  <= fpu_overflow;
        rsp_underflow <= fpu_underflow;
        rsp_valid     <= 1'b1;
      end
      if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef FPU_DP_SCHED_STICKY_FLAGS_EN
  // A flag captured on the same edge as sts_clear survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_overflow  <= 1'b0;
      sts_underflow <= 1'b0;
    end else begin
      if (capture && fpu_overflow)       sts_overflow  <= 1'b1;
      else if (sts_clear)                sts_overflow  <= 1'b0;
      if (capture && fpu_underflow)      sts_underflow <= 1'b1;
      else if (sts_clear)                sts_underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/fpu_dp_scheduler.md
Name: fpu_dp_scheduler

Overview:
- Round-robin scheduler that shares one fpu_dp double-precision FPU instance between NUM_REQ requesters.
- Accepts one operation at a time over a valid/ready request port and drives the FPU operands and opcode.
- Counts the FPU's fixed pipeline latency, captures the result and flags, and returns them with the requester ID over a valid/ready response port.
- Sits between the core/issue logic and the fpu_dp datapath.

Parameters:
- WIDTH, 64, operand/result width (IEEE-754 double).
- NUM_REQ, 2, number of requesters (2..4).
- FPU_LATENCY, 2, clock edges from stable operands until fpu_result is valid (≥1).
- ID_W, derived as max(1, clog2(NUM_REQ)), response ID width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing as req_a.
- req_op  in  2*NUM_REQ  opcode, requester i at [2i +: 2]; 00 add, 01 sub, 10 mul, 11 div.
- fpu_a  out  WIDTH  to FPU operand A.
- fpu_b  out  WIDTH  to FPU operand B.
- fpu_opcode  out  2  to FPU OpCode.
- fpu_result  in  WIDTH  FPU Result.
- fpu_overflow  in  1  FPU overflow flag.
- fpu_underflow  in  1  FPU underflow flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_result  out  WIDTH  captured result.
- rsp_overflow  out  1  captured overflow flag.
- rsp_underflow  out  1  captured underflow flag.
- rsp_id  out  ID_W  index of the requester that issued the operation.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset state:
  - State IDLE; all outputs 0 (req_ready, fpu_a/b/opcode, all rsp_* outputs).
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i], searching from (ptr+1) mod NUM_REQ with wrap.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - No valid request: all req_ready bits 0, stay in IDLE.
  - Accept happens on the edge where req_valid[i] & req_ready[i]. At that edge:
    - Latch A, B and op into the fpu_* registers; latch the ID.
    - ptr <= winner; cnt <= FPU_LATENCY; go to WAIT.
- WAIT:
  - req_ready all 0; fpu_a/b/opcode held stable.
  - cnt != 0: cnt decrements by 1 each cycle.
  - cnt == 0: capture fpu_result/fpu_overflow/fpu_underflow into the rsp_* registers, set rsp_valid, go to RESP.
- Latency: rsp_valid rises FPU_LATENCY+1 cycles after the accept edge (3 cycles at default).
- RESP:
  - rsp_* outputs held stable while rsp_valid & !rsp_ready.
  - On the rsp_ready edge: rsp_valid <= 0, go to IDLE.
  - No new request is accepted in the same cycle.
  - Minimum spacing between accepts is FPU_LATENCY+3 cycles.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
- Requester rule: a requester keeps req_valid and its operands stable until accepted. The scheduler never drops a request.
- Reset mid-operation: the in-flight operation is discarded and the block returns to IDLE immediately. rsp_valid does not assert for that operation.
- cnt width is clog2(FPU_LATENCY+1); it never wraps.
- Special values (NaN, Inf, zero) pass through unmodified; special-case handling belongs to the FPU.

Optional Feature:
- Macro FPU_DP_SCHED_STICKY_FLAGS_EN.
- Defined:
  - Adds input sts_clear (1) and outputs sts_overflow and sts_underflow (1 each).
  - A sticky bit sets on the capture edge when the captured flag is 1.
  - sts_clear clears both bits on the next edge; a simultaneous set wins over clear.
  - Reset value 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package fpu_dp_pkg:
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - FSM state encoding.
  - Constants DP_POS_INF=64'h7FF0000000000000 and DP_POS_ZERO=64'h0, shared with the FPU benches.
- Sub-module fpu_dp_rr_arbiter (NUM_REQ):
  - Inputs req, ptr, enable; output one-hot grant.
  - Purely combinational; pointer state stays in the scheduler.

Test Plan:
- Single op, default latency: req0 add, A=0x3FF0000000000000 (1.0), B=0x3FF0000000000000, rsp_ready=1 → rsp_valid 3 cycles after accept, rsp_result=0x4000000000000000, rsp_id=0, held for 1 cycle.
- Contention: req0 and req1 both valid from reset with mul 2.0×3.0 and sub 3.0−1.0 → req0 granted first (result 0x4018000000000000), then req1 (result 0x4000000000000000, rsp_id=1); req1 sees req_ready only after the first response handshake.
- Fairness: all NUM_REQ=4 requesters continuously valid for 8 ops → grant order 0,1,2,3,0,1,2,3; no grant to a requester with req_valid=0.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_* stable, all req_ready 0; on rsp_ready=1 the next accept occurs ≥1 cycle later.
- Reset mid-WAIT: assert rst_n=0 one cycle after accept → outputs 0 immediately, no rsp_valid after release, next grant goes to req0.
- FPU_DP_SCHED_STICKY_FLAGS_EN defined: mul 0x7FE0000000000000×0x4000000000000000 → rsp_overflow=1, sts_overflow=1 and remains 1 across a following clean add; pulse sts_clear → 0; clear coincident with a new overflow capture → stays 1.
